bit_serializer: RTL and testbench
=================================

BIT_SERIALIZER -- requirements
Module: bit_serializer

Interface
REQ-001 Parameter WIDTH, default 8: number of data bits per word; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts bit WIDTH-1 first, 0 shifts bit 0 first.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  request to accept pdata; sampled on the rising clk edge.
REQ-006 pdata  input  WIDTH  parallel word to serialize.
REQ-007 ready  output  1  block can accept a word this cycle.
REQ-008 Dout  output  1  serial bit stream; drives a downstream detector's Din.
REQ-009 Dvalid  output  1  Dout carries a valid stream bit this cycle.
REQ-010 last  output  1  current Dout is the final bit of the word.

Function
REQ-011 The state machine SHALL have states IDLE, SHIFT and PAR; PAR exists only when SER_PARITY_EN is defined.
REQ-012 In IDLE: ready=1, Dvalid=0, Dout=0, last=0.
REQ-013 A rising edge with load=1 and ready=1 SHALL capture pdata into the shift register, clear the bit counter, and enter SHIFT.
REQ-014 The first data bit SHALL appear on Dout with Dvalid=1 in the cycle immediately after the accepting edge (latency 1).
REQ-015 In SHIFT, one bit per cycle SHALL be presented, ordered per MSB_FIRST, for exactly WIDTH cycles.
REQ-016 Dout and Dvalid SHALL be registered outputs, free of combinational paths from load or pdata.
REQ-017 The bit counter SHALL be $clog2(WIDTH) bits wide and SHALL count 0..WIDTH-1 with no wrap past WIDTH-1.
REQ-018 last SHALL equal 1 on the final stream bit: data bit WIDTH-1 without parity, or the parity bit with parity.
REQ-019 ready SHALL also equal 1 in the cycle where last=1, so that back-to-back words stream with no gap cycle.
REQ-020 A load accepted while last=1 SHALL start the next word's first bit in the following cycle, and Dvalid SHALL remain 1 continuously.
REQ-021 When last=1 and load=0, the next state SHALL be IDLE.
REQ-022 load=1 while ready=0 SHALL be ignored: no capture, no state change, and the word is not queued.
REQ-023 Changes on pdata outside an accepting edge SHALL have no effect on the stream.

Reset
REQ-024 rst=0 SHALL immediately force: state IDLE, shift register 0, counter 0, Dout=0, Dvalid=0, last=0.
REQ-025 ready SHALL read 1 during reset.
REQ-026 Reset asserted mid-word SHALL abort the word, with no partial resumption after release.
REQ-027 The first load SHALL be accepted on the first rising edge after rst returns to 1.

Configuration
REQ-028 When macro SER_PARITY_EN is defined, PAR SHALL follow SHIFT for one cycle, driving the even-parity bit (XOR of the captured word) with Dvalid=1 and last=1.
REQ-029 When SER_PARITY_EN is defined, a word SHALL occupy WIDTH+1 stream cycles.
REQ-030 When SER_PARITY_EN is undefined, no parity logic or PAR state SHALL exist, and a word SHALL occupy WIDTH stream cycles.

Verification (WIDTH=8 unless stated)
REQ-031 MSB_FIRST=1, load 8'hA5 once -> Dout = 1,0,1,0,0,1,0,1 on cycles 1..8; Dvalid=1 on those cycles; last=1 on cycle 8 only; IDLE on cycle 9.
REQ-032 MSB_FIRST=0, load 8'h01 -> Dout = 1 then seven 0s; last on the eighth bit.
REQ-033 Load 8'hFF, then load 8'h00 held during the last=1 cycle -> 16 consecutive Dvalid=1 cycles (eight 1s, then eight 0s) with no gap.
REQ-034 Load 8'h3C, pulse load with 8'hFF on cycle 4 -> the stream remains 0,0,1,1,1,1,0,0; 8'hFF is never emitted.
REQ-035 Reset low on cycle 5 of word 8'hF0 -> Dout=0, Dvalid=0 and ready=1 immediately; after release, load 8'h81 streams 1,0,0,0,0,0,0,1 cleanly.
REQ-036 SER_PARITY_EN defined, load 8'h07 -> bits 0,0,0,0,0,1,1,1, then a ninth bit 1 with last=1; load 8'h03 -> ninth bit 0.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial shifter with registered stream outputs and gap-free back-to-back words.
// Define SER_PARITY_EN to append an even-parity bit (PAR state) after each word.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] pdata,
  output logic             ready,
  output logic             Dout,
  output logic             Dvalid,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

`ifdef SER_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic {IDLE, SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dvalid_q, dvalid_d;
  logic             last_q, last_d;
  logic             accept;
`ifdef SER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1];
    else                return w[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return {w[WIDTH-2:0], 1'b0};
    else                return {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      dout_q   <= 1'b0;
      dvalid_q <= 1'b0;
      last_q   <= 1'b0;
`ifdef SER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
      last_q   <= last_d;
`ifdef SER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  // Dout always presents the head of the shift register one cycle after it is computed,
  // so the bit after an accepting edge comes straight from pdata.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    dout_d   = 1'b0;
    dvalid_d = 1'b0;
    last_d   = 1'b0;
    accept   = load && ready;
`ifdef SER_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      IDLE: begin
        state_d = IDLE;
      end
      SHIFT: begin
        if (cnt_q != CNT_LAST) begin
          shreg_d  = shift_once(shreg_q);
          cnt_d    = cnt_q + CW'(1);
          dout_d   = head_bit(shreg_d);
          dvalid_d = 1'b1;
`ifdef SER_PARITY_EN
          last_d   = 1'b0;
`else
          last_d   = (cnt_d == CNT_LAST);
`endif
        end else begin
`ifdef SER_PARITY_EN
          state_d  = PAR;
          dout_d   = parity_q;
          dvalid_d = 1'b1;
          last_d   = 1'b1;
`else
          state_d  = IDLE;
          shreg_d  = '0;
          cnt_d    = '0;
`endif
        end
      end
`ifdef SER_PARITY_EN
      PAR: begin
        state_d = IDLE;
        shreg_d = '0;
        cnt_d   = '0;
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase

    // An accepted word overrides the return to IDLE, which is what makes back-to-back gap-free.
    if (accept) begin
      state_d  = SHIFT;
      shreg_d  = pdata;
      cnt_d    = '0;
      dout_d   = head_bit(pdata);
      dvalid_d = 1'b1;
      last_d   = 1'b0;
`ifdef SER_PARITY_EN
      parity_d = ^pdata;
`endif
    end
  end

  always_comb begin
    ready  = (state_q == IDLE) || last_q;
    Dout   = dout_q;
    Dvalid = dvalid_q;
    last   = last_q;
  end

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench: MSB-first and LSB-first serializers share stimulus and are each
// compared every cycle against a queue-based stream model.
module tb_bit_serializer;

  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int SL = W + 1;
`else
  localparam int SL = W;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] pdata = '0;
  logic ready_m, dout_m, dvalid_m, last_m;
  logic ready_l, dout_l, dvalid_l, last_l;

  int tests_run = 0;
  int tests_failed = 0;

  logic [1:0] q_m[$];
  logic [1:0] q_l[$];
  logic [2:0] cur_m = 3'b000;
  logic [2:0] cur_l = 3'b000;

  bit_serializer #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (
    .clk(clk), .rst(rst), .load(load), .pdata(pdata),
    .ready(ready_m), .Dout(dout_m), .Dvalid(dvalid_m), .last(last_m)
  );

  bit_serializer #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (
    .clk(clk), .rst(rst), .load(load), .pdata(pdata),
    .ready(ready_l), .Dout(dout_l), .Dvalid(dvalid_l), .last(last_l)
  );

  always #5 clk = ~clk;

  // Stream entry i of word w: {is_last, bit}; entry W (when present) is the even-parity bit.
  function automatic logic [1:0] stream_entry(input bit msb, input logic [W-1:0] w, input int i);
    logic b;
    if (i == W)  b = ^w;
    else if (msb) b = w[W-1-i];
    else          b = w[i];
    return {(i == SL - 1), b};
  endfunction

  // Expected {Dvalid, Dout, last, ready} from the model's presented entry {valid, last, bit}.
  function automatic logic [3:0] exp_vec(input logic [2:0] c);
    return {c[2], c[0], c[1], (!c[2]) || c[1]};
  endfunction

  task automatic model_edge(input logic ld, input logic [W-1:0] pd);
    if (ld && (!cur_m[2] || cur_m[1])) begin
      q_m.delete();
      for (int i = 0; i < SL; i++) q_m.push_back(stream_entry(1'b1, pd, i));
    end
    if (ld && (!cur_l[2] || cur_l[1])) begin
      q_l.delete();
      for (int i = 0; i < SL; i++) q_l.push_back(stream_entry(1'b0, pd, i));
    end
    if (q_m.size() > 0) cur_m = {1'b1, q_m.pop_front()};
    else                cur_m = 3'b000;
    if (q_l.size() > 0) cur_l = {1'b1, q_l.pop_front()};
    else                cur_l = 3'b000;
  endtask

  task automatic model_reset();
    q_m.delete();
    q_l.delete();
    cur_m = 3'b000;
    cur_l = 3'b000;
  endtask

  task automatic applyStimulus(input logic ld, input logic [W-1:0] pd);
    load  = ld;
    pdata = pd;
    @(posedge clk);
    model_edge(ld, pd);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    load = 1'b0;
    #2;
    tests_run++;
    if ({dvalid_m, dout_m, last_m, ready_m} !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_msb: got %b want 0001", {dvalid_m, dout_m, last_m, ready_m});
    end
    tests_run++;
    if ({dvalid_l, dout_l, last_l, ready_l} !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_lsb: got %b want 0001", {dvalid_l, dout_l, last_l, ready_l});
    end
    @(negedge clk);
    load  = 1'b1;
    pdata = W'($urandom);
    @(posedge clk);
    #1;
    tests_run++;
    if ({dvalid_m, dout_m, last_m, ready_m} !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL reset_load_ignored: got %b want 0001", {dvalid_m, dout_m, last_m, ready_m});
    end
    @(negedge clk);
    load = 1'b0;
    rst  = 1'b1;
    model_reset();
  endtask

  task automatic test_single_word();
    logic [W-1:0] words[2];
    logic [W-1:0] vm, vl;
    int n;
    words[0] = 8'hA5;
    words[1] = 8'h01;
    for (int k = 0; k < 2; k++) begin
      vm = '0;
      vl = '0;
      n  = 0;
      for (int c = 1; c <= SL + 1; c++) begin
        if (c == 1) applyStimulus(1'b1, words[k]);
        else        applyStimulus(1'b0, W'($urandom));
        tests_run++;
        if ({dvalid_m, dout_m, last_m, ready_m} !== exp_vec(cur_m)) begin
          tests_failed++;
          $display("[TB] FAIL single_msb word %h cycle %0d: got %b want %b", words[k], c, {dvalid_m, dout_m, last_m, ready_m}, exp_vec(cur_m));
        end
        tests_run++;
        if ({dvalid_l, dout_l, last_l, ready_l} !== exp_vec(cur_l)) begin
          tests_failed++;
          $display("[TB] FAIL single_lsb word %h cycle %0d: got %b want %b", words[k], c, {dvalid_l, dout_l, last_l, ready_l}, exp_vec(cur_l));
        end
        if (dvalid_m && n < W) begin
          vm = {vm[W-2:0], dout_m};
          vl = {dout_l, vl[W-1:1]};
          n++;
        end
      end
      tests_run++;
      if (vm !== words[k]) begin
        tests_failed++;
        $display("[TB] FAIL single_msb_word: got %h want %h", vm, words[k]);
      end
      tests_run++;
      if (vl !== words[k]) begin
        tests_failed++;
        $display("[TB] FAIL single_lsb_word: got %h want %h", vl, words[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    int max_run = 0;
    for (int c = 0; c <= 2 * SL + 1; c++) begin
      if (c == 0)       applyStimulus(1'b1, 8'hFF);
      else if (c <= SL) applyStimulus(1'b1, 8'h00);
      else              applyStimulus(1'b0, W'($urandom));
      tests_run++;
      if ({dvalid_m, dout_m, last_m, ready_m} !== exp_vec(cur_m)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_msb cycle %0d: got %b want %b", c, {dvalid_m, dout_m, last_m, ready_m}, exp_vec(cur_m));
      end
      tests_run++;
      if ({dvalid_l, dout_l, last_l, ready_l} !== exp_vec(cur_l)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_lsb cycle %0d: got %b want %b", c, {dvalid_l, dout_l, last_l, ready_l}, exp_vec(cur_l));
      end
      if (dvalid_m) run++;
      else          run = 0;
      if (run > max_run) max_run = run;
    end
    tests_run++;
    if (max_run != 2 * SL) begin
      tests_failed++;
      $display("[TB] FAIL b2b_valid_run: got %0d want %0d", max_run, 2 * SL);
    end
  endtask

  task automatic test_ignore_busy_load();
    logic [W-1:0] vm, vl;
    int n = 0;
    vm = '0;
    vl = '0;
    for (int c = 1; c <= SL + 1; c++) begin
      if (c == 1)      applyStimulus(1'b1, 8'h3C);
      else if (c == 4) applyStimulus(1'b1, 8'hFF);
      else             applyStimulus(1'b0, W'($urandom));
      tests_run++;
      if ({dvalid_m, dout_m, last_m, ready_m} !== exp_vec(cur_m)) begin
        tests_failed++;
        $display("[TB] FAIL ignore_msb cycle %0d: got %b want %b", c, {dvalid_m, dout_m, last_m, ready_m}, exp_vec(cur_m));
      end
      tests_run++;
      if ({dvalid_l, dout_l, last_l, ready_l} !== exp_vec(cur_l)) begin
        tests_failed++;
        $display("[TB] FAIL ignore_lsb cycle %0d: got %b want %b", c, {dvalid_l, dout_l, last_l, ready_l}, exp_vec(cur_l));
      end
      if (dvalid_m && n < W) begin
        vm = {vm[W-2:0], dout_m};
        vl = {dout_l, vl[W-1:1]};
        n++;
      end
    end
    tests_run++;
    if (vm !== 8'h3C || vl !== 8'h3C) begin
      tests_failed++;
      $display("[TB] FAIL ignore_word: got msb %h lsb %h want 3c", vm, vl);
    end
  endtask

  task automatic test_reset_midword();
    logic [W-1:0] vm, vl;
    int n = 0;
    vm = '0;
    vl = '0;
    applyStimulus(1'b1, 8'hF0);
    for (int c = 2; c <= 4; c++) applyStimulus(1'b0, W'($urandom));
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    tests_run++;
    if ({dvalid_m, dout_m, last_m, ready_m} !== 4'b0001 || {dvalid_l, dout_l, last_l, ready_l} !== 4'b0001) begin
      tests_failed++;
      $display("[TB] FAIL midword_reset: got msb %b lsb %b want 0001", {dvalid_m, dout_m, last_m, ready_m}, {dvalid_l, dout_l, last_l, ready_l});
    end
    @(negedge clk);
    rst = 1'b1;
    for (int c = 1; c <= SL + 1; c++) begin
      if (c == 1) applyStimulus(1'b1, 8'h81);
      else        applyStimulus(1'b0, W'($urandom));
      tests_run++;
      if ({dvalid_m, dout_m, last_m, ready_m} !== exp_vec(cur_m)) begin
        tests_failed++;
        $display("[TB] FAIL after_reset_msb cycle %0d: got %b want %b", c, {dvalid_m, dout_m, last_m, ready_m}, exp_vec(cur_m));
      end
      tests_run++;
      if ({dvalid_l, dout_l, last_l, ready_l} !== exp_vec(cur_l)) begin
        tests_failed++;
        $display("[TB] FAIL after_reset_lsb cycle %0d: got %b want %b", c, {dvalid_l, dout_l, last_l, ready_l}, exp_vec(cur_l));
      end
      if (dvalid_m && n < W) begin
        vm = {vm[W-2:0], dout_m};
        vl = {dout_l, vl[W-1:1]};
        n++;
      end
    end
    tests_run++;
    if (vm !== 8'h81 || vl !== 8'h81) begin
      tests_failed++;
      $display("[TB] FAIL after_reset_word: got msb %h lsb %h want 81", vm, vl);
    end
  endtask

`ifdef SER_PARITY_EN
  task automatic test_parity();
    logic [W-1:0] words[2];
    logic par_exp[2];
    words[0] = 8'h07;  par_exp[0] = 1'b1;
    words[1] = 8'h03;  par_exp[1] = 1'b0;
    for (int k = 0; k < 2; k++) begin
      for (int c = 1; c <= SL + 1; c++) begin
        if (c == 1) applyStimulus(1'b1, words[k]);
        else        applyStimulus(1'b0, W'($urandom));
        tests_run++;
        if ({dvalid_m, dout_m, last_m, ready_m} !== exp_vec(cur_m)) begin
          tests_failed++;
          $display("[TB] FAIL parity_msb word %h cycle %0d: got %b want %b", words[k], c, {dvalid_m, dout_m, last_m, ready_m}, exp_vec(cur_m));
        end
        if (c == SL) begin
          tests_run++;
          if ({dvalid_m, dout_m, last_m} !== {1'b1, par_exp[k], 1'b1} || {dvalid_l, dout_l, last_l} !== {1'b1, par_exp[k], 1'b1}) begin
            tests_failed++;
            $display("[TB] FAIL parity_bit word %h: got msb %b lsb %b want %b", words[k], {dvalid_m, dout_m, last_m}, {dvalid_l, dout_l, last_l}, {1'b1, par_exp[k], 1'b1});
          end
        end
      end
    end
  endtask
`endif

  task automatic test_random();
    logic ld;
    for (int c = 0; c < 300; c++) begin
      ld = ($urandom_range(0, 3) == 0);
      applyStimulus(ld, W'($urandom));
      tests_run++;
      if ({dvalid_m, dout_m, last_m, ready_m} !== exp_vec(cur_m)) begin
        tests_failed++;
        $display("[TB] FAIL random_msb cycle %0d: got %b want %b", c, {dvalid_m, dout_m, last_m, ready_m}, exp_vec(cur_m));
      end
      tests_run++;
      if ({dvalid_l, dout_l, last_l, ready_l} !== exp_vec(cur_l)) begin
        tests_failed++;
        $display("[TB] FAIL random_lsb cycle %0d: got %b want %b", c, {dvalid_l, dout_l, last_l, ready_l}, exp_vec(cur_l));
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_ignore_busy_load();
    test_reset_midword();
`ifdef SER_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
